// File: rtl/enc8to3_seq.sv
// Sequential N-to-CW encoder: captures a request vector, emits one code per set bit.
// Optional zero-vector error pulse on err when ENC_ZERO_ERR_EN is defined.
module enc8to3_seq #(
  parameter int N         = 8,
  parameter int CW        = 3,
  parameter int MSB_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  in_vec,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  rem;
  logic [CW-1:0] code_q, code_d;
  logic          last_q, last_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;

  function automatic logic [CW-1:0] first_idx(input logic [N-1:0] v);
    first_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (MSB_FIRST != 0) begin
        if (v[i]) first_idx = CW'(i);
      end else if (v[N-1-i]) begin
        first_idx = CW'(N-1-i);
      end
    end
  endfunction

  function automatic logic one_hot(input logic [N-1:0] v);
    one_hot = (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  assign rem = pend_q & ~(N'(1) << code_q);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    code_d  = code_q;
    last_d  = last_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (en && in_valid && in_vec != '0) begin
          pend_d  = in_vec;
          code_d  = first_idx(in_vec);
          last_d  = one_hot(in_vec);
          vld_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (en && out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            rdy_d   = 1'b1;
            pend_d  = '0;
          end else begin
            pend_d = rem;
            code_d = first_idx(rem);
            last_d = one_hot(rem);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      last_q  <= last_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = rdy_q & en;
  assign out_valid = vld_q;
  assign out_code  = code_q;
  assign out_last  = last_q;

`ifdef ENC_ZERO_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= en && rdy_q && in_valid && (in_vec == '0);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed bench for enc8to3_seq: LSB-first and MSB-first instances in lockstep.
module tb_enc8to3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready, out_valid, out_last, err;
  logic [2:0] out_code;
  logic       in_ready_m, valid_m, last_m, err_m;
  logic [2:0] code_m;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enc8to3_seq #(.N(8), .CW(3), .MSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
    .out_code(out_code), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .err(err)
  );

  enc8to3_seq #(.N(8), .CW(3), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_code(code_m), .out_valid(valid_m),
    .out_ready(out_ready), .out_last(last_m), .err(err_m)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    in_vec   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  logic exp_err;
  int   e;
  int   k;
  logic [3:0] pat;

  initial begin
    rst_n = 1'b0; en = 1'b1; in_vec = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    pat = 4'b1001;
    step();
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_code", out_code, 0);
    check("rst_last", out_last, 0);
    check("rst_err", err, 0);
    step();
    rst_n = 1'b1;
    step();

    // reset asserted mid-EMIT after 3 beats
    send(8'hFF);
    check("r1_code0", out_code, 0);
    step(); step(); step();
    check("r1_code3", out_code, 3);
    check("r1_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("r1_rst_valid", out_valid, 0);
    check("r1_rst_ready", in_ready, 1);
    check("r1_rst_err", err, 0);
    step();
    rst_n = 1'b1;
    step();

    // single bit
    send(8'b0001_0000);
    check("s_valid", out_valid, 1);
    check("s_code", out_code, 4);
    check("s_last", out_last, 1);
    check("s_ready", in_ready, 0);
    check("s_code_m", code_m, 4);
    step();
    check("s_done_valid", out_valid, 0);
    check("s_done_ready", in_ready, 1);

    // multi-hot, both orders
    send(8'b1000_0101);
    check("m_code0", out_code, 0);
    check("m_last0", out_last, 0);
    check("m_code0_m", code_m, 7);
    check("m_last0_m", last_m, 0);
    step();
    check("m_code1", out_code, 2);
    check("m_last1", out_last, 0);
    check("m_code1_m", code_m, 2);
    step();
    check("m_code2", out_code, 7);
    check("m_last2", out_last, 1);
    check("m_code2_m", code_m, 0);
    check("m_last2_m", last_m, 1);
    step();
    check("m_done", out_valid, 0);
    check("m_done_m", valid_m, 0);

    // back-pressure, out_ready 1,0,0,1,...
    out_ready = 1'b0;
    send(8'hFF);
    e = 0;
    for (int c = 0; c < 40 && e < 8; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_code", out_code, e);
      check("bp_last", out_last, (e == 7) ? 1 : 0);
      check("bp_code_m", code_m, 7 - e);
      out_ready = pat[c % 4];
      step();
      if (out_ready) e++;
    end
    check("bp_accepts", e, 8);
    check("bp_done", out_valid, 0);
    out_ready = 1'b1;

    // en low for 3 cycles mid-EMIT
    send(8'hFF);
    step();
    check("en_code1", out_code, 1);
    en = 1'b0;
    #1;
    check("en_ready", in_ready, 0);
    check("en_ready_m", in_ready_m, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("en_hold_code", out_code, 1);
      check("en_hold_valid", out_valid, 1);
    end
    en = 1'b1;
    step();
    check("en_resume", out_code, 2);
    k = 2;
    for (int c = 0; c < 20 && out_valid; c++) begin
      check("en_drain", out_code, k);
      step();
      k++;
    end
    check("en_beats", k, 8);
    check("en_done", out_valid, 0);

    // en low in IDLE blocks capture
    en = 1'b0;
    #1;
    check("idle_en_ready", in_ready, 0);
    send(8'h10);
    check("idle_en_nocap", out_valid, 0);
    en = 1'b1;
    #1;
    check("idle_en_back", in_ready, 1);

    // zero vector
`ifdef ENC_ZERO_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(8'h00);
    check("z_err", err, exp_err);
    check("z_valid", out_valid, 0);
    check("z_ready", in_ready, 1);
    step();
    check("z_err_clear", err, 0);
    check("z_ready2", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
